// File: rtl/lexington_pkg.sv
// Shared types and default end-of-test codes for the test monitor.
// Imported by test_monitor and fail_log.
package lexington_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASSED  = 2'd1,
    ST_FAILED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_e;

  localparam logic [31:0] SUCCESS_CODE_DEF = 32'h0D15EA5E;
  localparam logic [31:0] FAIL_CODE_DEF    = 32'hDEADBEEF;

endpackage

// File: rtl/test_monitor_fail_log.sv
// fail_log: synchronous FIFO of failing PCs with sticky overflow.
// DEPTH must be a power of two, at least 2.
module fail_log
  import lexington_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             ovf_q, ovf_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // a pop frees the slot the same cycle, so full+push+pop is accepted
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      ovf_d = 1'b0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
      if (push && !push_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_q[AW-1:0]] <= wdata;
  end

  assign rdata    = empty ? '0 : mem[rd_q[AW-1:0]];
  assign overflow = ovf_q;

endmodule

// File: rtl/test_monitor.sv
// test_monitor: ebreak-driven pass/fail scoreboard with watchdog.
// Failing-PC log is built only with TEST_MONITOR_PC_LOG_EN defined.
module test_monitor
  import lexington_pkg::*;
#(
  parameter int unsigned MAX_CYCLES   = 1024,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter logic [31:0] SUCCESS_CODE = SUCCESS_CODE_DEF,
  parameter logic [31:0] FAIL_CODE    = FAIL_CODE_DEF,
  parameter int unsigned LOG_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 ebreak,
  input  logic [31:0]          a0,
  input  logic [31:0]          a1,
  input  logic [31:0]          ra,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] fail_count,
  output logic                 done,
  output logic                 passed,
  output logic                 timeout,
  input  logic                 log_rd_en,
  output logic [31:0]          log_rd_data,
  output logic                 log_empty,
  output logic                 log_overflow
);

  localparam int unsigned CYC_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);

  mon_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] pass_q, pass_d;
  logic [CNT_WIDTH-1:0] fail_q, fail_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic                 log_push;
  logic                 is_succ;
  logic                 is_fail;

  assign is_succ = (a0 == SUCCESS_CODE);
  assign is_fail = (a0 == FAIL_CODE);

  // watchdog is set first so a terminal ebreak on the same cycle wins
  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    cyc_d    = cyc_q;
    log_push = 1'b0;
    if (clear) begin
      state_d = ST_RUN;
      pass_d  = '0;
      fail_d  = '0;
      cyc_d   = '0;
    end else if (state_q == ST_RUN) begin
      cyc_d = cyc_q + 1'b1;
      if (cyc_q == CYC_LAST) state_d = ST_TIMEOUT;
      if (ebreak) begin
        unique case (1'b1)
          is_succ: state_d = (fail_q == '0) ? ST_PASSED : ST_FAILED;
          is_fail: state_d = ST_FAILED;
          default: begin
            if (a0 == a1) begin
              if (!(&pass_q)) pass_d = pass_q + 1'b1;
            end else begin
              if (!(&fail_q)) fail_d = fail_q + 1'b1;
              log_push = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pass_q  <= '0;
      fail_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      cyc_q   <= cyc_d;
    end
  end

  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign done       = (state_q != ST_RUN);
  assign passed     = (state_q == ST_PASSED);
  assign timeout    = (state_q == ST_TIMEOUT);

`ifdef TEST_MONITOR_PC_LOG_EN
  logic unused_full;

  fail_log #(
    .DEPTH (LOG_DEPTH),
    .WIDTH (32)
  ) u_fail_log (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clear),
    .push     (log_push),
    .wdata    (ra - 32'd4),
    .pop      (log_rd_en),
    .rdata    (log_rd_data),
    .empty    (log_empty),
    .full     (unused_full),
    .overflow (log_overflow)
  );
`else
  logic unused_log;

  assign unused_log   = ^{log_rd_en, ra, log_push, LOG_DEPTH[0]};
  assign log_rd_data  = '0;
  assign log_empty    = 1'b1;
  assign log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_test_monitor.sv
// Scoreboard bench for test_monitor against a queue-based reference model.
module tb_test_monitor;

  localparam int MAXC  = 1024;
  localparam int CMAX  = 15;
  localparam int DEPTH = 4;
  localparam logic [31:0] SUCC  = 32'h0D15EA5E;
  localparam logic [31:0] FAILC = 32'hDEADBEEF;
`ifdef TEST_MONITOR_PC_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        ebreak;
  logic [31:0] a0, a1, ra;
  logic [3:0]  pass_count, fail_count;
  logic        done, passed, timeout;
  logic        log_rd_en;
  logic [31:0] log_rd_data;
  logic        log_empty, log_overflow;

  always #5 clk = ~clk;

  test_monitor #(
    .MAX_CYCLES (MAXC),
    .CNT_WIDTH  (4),
    .LOG_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .ebreak       (ebreak),
    .a0           (a0),
    .a1           (a1),
    .ra           (ra),
    .pass_count   (pass_count),
    .fail_count   (fail_count),
    .done         (done),
    .passed       (passed),
    .timeout      (timeout),
    .log_rd_en    (log_rd_en),
    .log_rd_data  (log_rd_data),
    .log_empty    (log_empty),
    .log_overflow (log_overflow)
  );

  typedef struct {
    bit          done;
    bit          passed;
    bit          tmo;
    int          pc;
    int          fc;
    bit          emp;
    logic [31:0] head;
    bit          ovf;
    string       tag;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  // reference model
  bit          m_done, m_passed, m_tmo, m_ovf;
  int          m_pc, m_fc, m_cyc;
  logic [31:0] m_log[$];
  bit          rst_req;
  string       cur_tag;

  task automatic model_reset();
    m_done = 0; m_passed = 0; m_tmo = 0; m_ovf = 0;
    m_pc = 0; m_fc = 0; m_cyc = 0;
    m_log.delete();
  endtask

  task automatic step(input bit cl, input bit eb,
                      input logic [31:0] x0, input logic [31:0] x1,
                      input logic [31:0] xr, input bit rd);
    snap_t s;
    @(negedge clk);
    rst_n = rst_req; clear = cl; ebreak = eb;
    a0 = x0; a1 = x1; ra = xr; log_rd_en = rd;
    if (!rst_req || cl) begin
      model_reset();
    end else begin
      if (rd && m_log.size() > 0) void'(m_log.pop_front());
      if (!m_done) begin
        m_cyc++;
        if (eb) begin
          if (x0 == SUCC) begin
            m_done = 1; m_passed = (m_fc == 0);
          end else if (x0 == FAILC) begin
            m_done = 1;
          end else if (x0 == x1) begin
            if (m_pc < CMAX) m_pc++;
          end else begin
            if (m_fc < CMAX) m_fc++;
            if (LOG_EN) begin
              if (m_log.size() < DEPTH) m_log.push_back(xr - 32'd4);
              else m_ovf = 1;
            end
          end
        end
        if (!m_done && m_cyc >= MAXC) begin
          m_done = 1; m_tmo = 1;
        end
      end
    end
    s.done = m_done; s.passed = m_passed; s.tmo = m_tmo;
    s.pc = m_pc; s.fc = m_fc; s.ovf = m_ovf;
    s.emp = (m_log.size() == 0);
    s.head = (m_log.size() > 0) ? m_log[0] : 32'd0;
    s.tag = cur_tag;
    exp_q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] v;
    do v = $urandom; while (v == SUCC || v == FAILC);
    return v;
  endfunction

  // monitor: compare DUT state after every active edge
  initial begin
    snap_t s;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        checks++;
        if (done !== s.done || passed !== s.passed ||
            timeout !== s.tmo || int'(pass_count) != s.pc ||
            int'(fail_count) != s.fc || log_empty !== s.emp ||
            log_rd_data !== s.head || log_overflow !== s.ovf) begin
          failures++;
          if (failures <= 20)
            $display("FAIL %s: got d/p/t=%0b%0b%0b pc=%0d fc=%0d emp=%0b head=%h ovf=%0b exp d/p/t=%0b%0b%0b pc=%0d fc=%0d emp=%0b head=%h ovf=%0b",
                     s.tag, done, passed, timeout, pass_count,
                     fail_count, log_empty, log_rd_data, log_overflow,
                     s.done, s.passed, s.tmo, s.pc, s.fc, s.emp,
                     s.head, s.ovf);
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    rst_req = 0; rst_n = 0; clear = 0; ebreak = 0;
    a0 = 0; a1 = 0; ra = 0; log_rd_en = 0;
    model_reset();

    cur_tag = "reset";
    for (int i = 0; i < 3; i++)
      step(0, 1, rnd_word(), rnd_word(), rnd_word(), 1);
    rst_req = 1;

    cur_tag = "three_pass_success";
    for (int i = 0; i < 3; i++) begin
      w = rnd_word();
      step(0, 1, w, w, rnd_word(), 0);
    end
    step(0, 1, SUCC, rnd_word(), rnd_word(), 0);
    idle(2);
    cur_tag = "terminal_ignores_ebreak";
    step(0, 1, 32'd5, 32'd6, 32'h200, 0);
    step(0, 1, FAILC, 32'd0, 32'h300, 0);

    cur_tag = "one_fail_then_success";
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'd5, 32'd6, 32'h104, 0);
    step(0, 1, SUCC, 32'd0, 32'd0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 1);
    idle(1);

    cur_tag = "log_overflow";
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 32'd1, 32'd2, 32'h1000 + 32'(i * 16), 0);
    cur_tag = "full_push_pop";
    step(0, 1, 32'd7, 32'd8, 32'h2004, 1);
    cur_tag = "log_drain";
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);

    cur_tag = "saturation";
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 32'd9, 32'd9, 0, 0);
    for (int i = 0; i < 17; i++)
      step(0, 1, 32'd9, 32'd8, rnd_word(), 0);
    step(0, 1, FAILC, 0, 0, 0);
    idle(1);

    cur_tag = "clear_beats_ebreak";
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 32'd4, 32'd4, 0, 0);
    step(1, 1, SUCC, 0, 0, 0);
    step(1, 1, 32'd4, 32'd5, 32'h50, 0);
    idle(1);

    cur_tag = "random_mix";
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [31:0] x0;
      r = $urandom_range(0, 19);
      x0 = (r == 0) ? SUCC : (r == 1) ? FAILC : 32'($urandom_range(0, 3));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
           x0, 32'($urandom_range(0, 3)), $urandom,
           ($urandom_range(0, 3) == 0));
    end

    cur_tag = "timeout";
    step(1, 0, 0, 0, 0, 0);
    idle(MAXC + 2);

    cur_tag = "success_at_limit";
    step(1, 0, 0, 0, 0, 0);
    idle(MAXC - 1);
    step(0, 1, SUCC, 0, 0, 0);
    idle(2);

    cur_tag = "check_at_limit";
    step(1, 0, 0, 0, 0, 0);
    idle(MAXC - 1);
    step(0, 1, 32'd3, 32'd4, 32'h40, 0);
    idle(2);

    cur_tag = "reset_mid_run";
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'd1, 32'd1, 0, 0);
    step(0, 1, 32'd1, 32'd2, 32'h84, 0);
    rst_req = 0;
    step(0, 1, 32'd1, 32'd2, 32'h88, 0);
    step(1, 1, SUCC, 0, 0, 1);
    rst_req = 1;
    idle(2);
    step(0, 1, 32'd2, 32'd2, 0, 0);
    idle(1);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected snapshots left, 0 required",
               exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
